// File: rtl/rgb_stream_proc.sv
// Per-pixel RGB stream processor: frame-synchronous colour mode applied to NumPix lanes,
// carried with vsync/hsync/vde through a fixed-latency, stallable valid/ready pipeline.
module rgb_stream_proc #(
   parameter int unsigned PixW    = 8,
   parameter int unsigned NumPix  = 1,
   parameter int unsigned Latency = 2,
   parameter int unsigned CntW    = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [2:0]                  mode_i,
   input  logic [PixW-1:0]             thresh_i,
   input  logic [NumPix*3*PixW-1:0]    pix_i,
   input  logic                        vsync_i,
   input  logic                        hsync_i,
   input  logic                        vde_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   output logic [NumPix*3*PixW-1:0]    pix_o,
   output logic                        vsync_o,
   output logic                        hsync_o,
   output logic                        vde_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [2:0]                  mode_o,
   output logic [CntW-1:0]             frame_cnt_o
);

   localparam int unsigned LaneW = 3 * PixW;
   localparam int unsigned BeatW = NumPix * LaneW;

   typedef enum logic [2:0] {
      ModePass   = 3'd0,
      ModeInv    = 3'd1,
      ModeGray   = 3'd2,
      ModeThresh = 3'd3,
      ModeSwap   = 3'd4
   } mode_e;

   logic [Latency-1:0] valid_q;
   logic [Latency-1:0] load;
   logic [BeatW-1:0]   pix_q  [Latency];
   logic [2:0]         meta_q [Latency];

   logic [2:0]         mode_q;
   logic [PixW-1:0]    thresh_q;
   logic [CntW-1:0]    frame_cnt_q;
   logic               prev_vsync_q;

   logic               accept;
   logic               frame_start;
   logic [2:0]         mode_eff;
   logic [PixW-1:0]    thresh_eff;
   logic [BeatW-1:0]   pix_proc;

   logic               full_tail;
   logic [PixW-1:0]    r;
   logic [PixW-1:0]    g;
   logic [PixW-1:0]    b;
   logic [PixW+1:0]    sum;
   logic [PixW-1:0]    y;
   logic [LaneW-1:0]   lane;

   // Stage k can load unless it and every stage after it are full while the output stalls.
   always_comb begin
      load      = '0;
      full_tail = 1'b1;
      for (int k = 0; k < int'(Latency); k++) begin
         full_tail = 1'b1;
         for (int j = k; j < int'(Latency); j++) begin
            full_tail = full_tail & valid_q[j];
         end
         load[k] = ready_i | ~full_tail;
      end
   end

   assign ready_o     = load[0];
   assign accept      = valid_i & load[0];
   assign frame_start = accept & vsync_i & ~prev_vsync_q;
   // The boundary beat already uses the newly requested mode and threshold.
   assign mode_eff    = frame_start ? mode_i : mode_q;
   assign thresh_eff  = frame_start ? thresh_i : thresh_q;

   always_comb begin
      pix_proc = '0;
      r        = '0;
      g        = '0;
      b        = '0;
      sum      = '0;
      y        = '0;
      lane     = '0;
      for (int i = 0; i < int'(NumPix); i++) begin
         r    = pix_i[i*LaneW + 2*PixW +: PixW];
         g    = pix_i[i*LaneW + PixW +: PixW];
         b    = pix_i[i*LaneW +: PixW];
         sum  = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
         y    = sum[PixW+1:2];
         case (mode_e'(mode_eff))
            ModeInv:    lane = ~{r, g, b};
            ModeGray:   lane = {y, y, y};
            ModeThresh: lane = (y >= thresh_eff) ? {LaneW{1'b1}} : '0;
            ModeSwap:   lane = {b, g, r};
            default:    lane = {r, g, b};
         endcase
         if (!vde_i) begin
            lane = '0;
         end
         pix_proc[i*LaneW +: LaneW] = lane;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q      <= '0;
         for (int k = 0; k < int'(Latency); k++) begin
            pix_q[k]  <= '0;
            meta_q[k] <= '0;
         end
         mode_q       <= '0;
         thresh_q     <= '0;
         frame_cnt_q  <= '0;
         prev_vsync_q <= 1'b0;
      end else begin
         if (load[0]) begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
               pix_q[0]  <= pix_proc;
               meta_q[0] <= {vsync_i, hsync_i, vde_i};
            end
         end
         for (int k = 1; k < int'(Latency); k++) begin
            if (load[k]) begin
               valid_q[k] <= valid_q[k-1];
               if (valid_q[k-1]) begin
                  pix_q[k]  <= pix_q[k-1];
                  meta_q[k] <= meta_q[k-1];
               end
            end
         end
         if (accept) begin
            prev_vsync_q <= vsync_i;
         end
         if (frame_start) begin
            mode_q      <= mode_i;
            thresh_q    <= thresh_i;
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end

   assign valid_o                   = valid_q[Latency-1];
   assign pix_o                     = pix_q[Latency-1];
   assign {vsync_o, hsync_o, vde_o} = meta_q[Latency-1];
   assign mode_o                    = mode_q;
   assign frame_cnt_o               = frame_cnt_q;

endmodule

// File: tb/tb_rgb_stream_proc.sv
// Scoreboard bench for rgb_stream_proc: one-lane DUT plus a two-lane DUT driven in lockstep,
// lane 1 fed with the bitwise inverse of lane 0.
module tb_rgb_stream_proc;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [2:0]  mode_i;
   logic [7:0]  thresh_i;
   logic [23:0] pix_i;
   logic [47:0] pix2_i;
   logic        vsync_i, hsync_i, vde_i, valid_i;
   logic        ready_i = 1'b0;

   logic        ready_o, vsync_o, hsync_o, vde_o, valid_o;
   logic [23:0] pix_o;
   logic [2:0]  mode_o;
   logic [7:0]  frame_cnt_o;

   logic        ready2_o, vsync2_o, hsync2_o, vde2_o, valid2_o;
   logic [47:0] pix2_o;
   logic [2:0]  mode2_o;
   logic [7:0]  frame_cnt2_o;

   assign pix2_i = {~pix_i, pix_i};

   always #5 clk_i = ~clk_i;

   rgb_stream_proc #(.PixW(8), .NumPix(1), .Latency(2), .CntW(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .thresh_i(thresh_i), .pix_i(pix_i),
      .vsync_i(vsync_i), .hsync_i(hsync_i), .vde_i(vde_i), .valid_i(valid_i), .ready_o(ready_o),
      .pix_o(pix_o), .vsync_o(vsync_o), .hsync_o(hsync_o), .vde_o(vde_o), .valid_o(valid_o),
      .ready_i(ready_i), .mode_o(mode_o), .frame_cnt_o(frame_cnt_o)
   );

   rgb_stream_proc #(.PixW(8), .NumPix(2), .Latency(2), .CntW(8)) dut2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .thresh_i(thresh_i), .pix_i(pix2_i),
      .vsync_i(vsync_i), .hsync_i(hsync_i), .vde_i(vde_i), .valid_i(valid_i), .ready_o(ready2_o),
      .pix_o(pix2_o), .vsync_o(vsync2_o), .hsync_o(hsync2_o), .vde_o(vde2_o), .valid_o(valid2_o),
      .ready_i(ready_i), .mode_o(mode2_o), .frame_cnt_o(frame_cnt2_o)
   );

   typedef struct packed {
      logic [23:0] p0;
      logic [23:0] p1;
      logic [2:0]  meta;
   } exp_t;

   exp_t        sb[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   int          rdy_mode  = 0;
   logic [2:0]  act_mode  = 3'd0;
   logic [7:0]  act_thr   = 8'd0;
   logic        prev_vs   = 1'b0;
   logic [7:0]  fcnt      = 8'd0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Independent reference for lane 1 of the two-lane instance.
   function automatic logic [23:0] colour(input logic [23:0] p, input logic [2:0] m,
                                          input logic [7:0] th, input logic de);
      int         yi;
      logic [7:0] y8;
      yi = (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
      y8 = yi[7:0];
      if (!de) return 24'h0;
      case (m)
         3'd1:    return ~p;
         3'd2:    return {y8, y8, y8};
         3'd3:    return (y8 >= th) ? 24'hFFFFFF : 24'h0;
         3'd4:    return {p[7:0], p[15:8], p[23:16]};
         default: return p;
      endcase
   endfunction

   task automatic send(input logic [23:0] p, input logic [23:0] e,
                       input logic vs, input logic hs, input logic de);
      int n = 0;
      @(negedge clk_i);
      pix_i = p; vsync_i = vs; hsync_i = hs; vde_i = de; valid_i = 1'b1;
      #1;
      while (!ready_o && n < 200) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      if (!ready_o) begin
         $display("FAIL send_timeout: got ready_o 0, expected 1 within 200 cycles");
         total_cnt++;
         valid_i = 1'b0;
         return;
      end
      if (vs && !prev_vs) begin
         act_mode = mode_i;
         act_thr  = thresh_i;
         fcnt     = fcnt + 8'd1;
      end
      prev_vs = vs;
      sb.push_back('{p0: e, p1: colour(~p, act_mode, act_thr, de), meta: {vs, hs, de}});
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   // Blank filler beat ends the frame, then the vsync beat opens a new one.
   task automatic boundary(input logic [2:0] m, input logic [7:0] t,
                           input logic [23:0] p, input logic [23:0] e);
      mode_i   = m;
      thresh_i = t;
      send(24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);
      send(p, e, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   exp_t        mon_e;
   logic        held = 1'b0;
   logic [23:0] held_pix;
   logic [2:0]  held_meta;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         held = 1'b0;
      end else begin
         case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = 1'($urandom_range(0, 1));
            default: ready_i = 1'b0;
         endcase
         if (held) begin
            chk("stall_valid", 64'(valid_o), 64'd1);
            chk("stall_pix", 64'(pix_o), 64'(held_pix));
            chk("stall_meta", 64'({vsync_o, hsync_o, vde_o}), 64'(held_meta));
         end
         if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
               $display("FAIL unexpected_beat: got pix %0h, expected no beat", pix_o);
               total_cnt++;
            end else begin
               mon_e = sb.pop_front();
               chk("out_pix", 64'(pix_o), 64'(mon_e.p0));
               chk("out_meta", 64'({vsync_o, hsync_o, vde_o}), 64'(mon_e.meta));
               chk("lane2_valid", 64'(valid2_o), 64'd1);
               chk("lane2_pix", 64'(pix2_o), 64'({mon_e.p1, mon_e.p0}));
               chk("lane2_meta", 64'({vsync2_o, hsync2_o, vde2_o}), 64'(mon_e.meta));
            end
         end
         held      = valid_o && !ready_i;
         held_pix  = pix_o;
         held_meta = {vsync_o, hsync_o, vde_o};
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, expected finish before 300000 time units");
      $fatal(1);
   end

   initial begin
      rst_ni = 1'b0; valid_i = 1'b0; mode_i = 3'd0; thresh_i = 8'd0;
      pix_i = 24'h0; vsync_i = 1'b0; hsync_i = 1'b0; vde_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_pix", 64'(pix_o), 64'd0);
      chk("rst_meta", 64'({vsync_o, hsync_o, vde_o}), 64'd0);
      chk("rst_mode", 64'(mode_o), 64'd0);
      chk("rst_fcnt", 64'(frame_cnt_o), 64'd0);
      @(posedge clk_i);
      #2 rst_ni = 1'b1;

      // Passthrough and latency
      send(24'h123456, 24'h123456, 1'b0, 1'b1, 1'b1);
      chk("lat_t0", 64'(valid_o), 64'd0);
      @(posedge clk_i);
      #1 chk("lat_t1", 64'(valid_o), 64'd1);

      // Backpressure with random ready
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) send(24'(i + 1), 24'(i + 1), 1'b0, 1'b0, 1'b1);
      rdy_mode = 0;
      drain();

      // Fill with ready low, then reset with beats in flight
      rdy_mode = 2;
      send(24'h0000A1, 24'h0000A1, 1'b0, 1'b0, 1'b1);
      chk("rdy_after1", 64'(ready_o), 64'd1);
      send(24'h0000A2, 24'h0000A2, 1'b0, 1'b0, 1'b1);
      chk("rdy_after2", 64'(ready_o), 64'd0);
      chk("inflight_valid", 64'(valid_o), 64'd1);
      #2 rst_ni = 1'b0;
      #1 chk("async_rst_valid", 64'(valid_o), 64'd0);
      chk("async_rst_pix", 64'(pix_o), 64'd0);
      sb.delete();
      act_mode = 3'd0; act_thr = 8'd0; prev_vs = 1'b0; fcnt = 8'd0;
      rdy_mode = 0;
      repeat (2) @(posedge clk_i);
      #2 rst_ni = 1'b1;
      chk("post_rst_mode", 64'(mode_o), 64'd0);
      chk("post_rst_fcnt", 64'(frame_cnt_o), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         #1 chk("no_stale", 64'(valid_o), 64'd0);
      end

      // Frame-synchronous modes
      boundary(3'd1, 8'h00, 24'h00FF80, 24'hFF007F);
      chk("mode_inv", 64'(mode_o), 64'd1);
      chk("fcnt_1", 64'(frame_cnt_o), 64'd1);
      mode_i = 3'd2;
      send(24'h00FF80, 24'hFF007F, 1'b1, 1'b0, 1'b1);
      chk("midframe_mode", 64'(mode_o), 64'd1);
      chk("midframe_fcnt", 64'(frame_cnt_o), 64'd1);
      boundary(3'd2, 8'h00, 24'h102030, 24'h202020);
      send(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 1'b1);
      boundary(3'd3, 8'h20, 24'h102030, 24'hFFFFFF);
      boundary(3'd3, 8'h21, 24'h102030, 24'h000000);
      boundary(3'd4, 8'h00, 24'h123456, 24'h563412);
      chk("mode_swap", 64'(mode_o), 64'd4);
      send(24'h123456, 24'h563412, 1'b1, 1'b0, 1'b1);
      boundary(3'd1, 8'h00, 24'h00FF80, 24'hFF007F);
      send(24'hABCDEF, 24'h000000, 1'b0, 1'b1, 1'b0);
      drain();

      // Frame counter wrap
      for (int i = 0; i < 300 && fcnt != 8'd255; i++) boundary(3'd0, 8'h00, 24'(i), 24'(i));
      chk("fcnt_255", 64'(frame_cnt_o), 64'd255);
      boundary(3'd0, 8'h00, 24'h0F0F0F, 24'h0F0F0F);
      chk("fcnt_wrap", 64'(frame_cnt_o), 64'd0);
      drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/rgb_stream_proc.md
Name: rgb_stream_proc

Overview:
- Parametrised per-pixel RGB stream processor with valid/ready input and output streams; sideband metadata (vsync, hsync, vde) travels in lockstep with the pixel data.
- Applies a frame-synchronous colour mode: passthrough, invert, grayscale, threshold or R/B swap.
- Carries NumPix pixels per beat through a fixed-latency, stallable pipeline.
- Sits between the video input stage and the display output stage.

Parameters:
- PixW, 8, bits per colour channel.
- NumPix, 1, pixels per beat (lanes). Lane i occupies bits [i*3*PixW +: 3*PixW], packed {r,g,b}, r at MSB.
- Latency, 2, pipeline stages from input to output. Must be at least 1.
- CntW, 8, frame counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- mode_i  in  3  requested mode.
- thresh_i  in  PixW  requested threshold level.
- pix_i  in  NumPix*3*PixW  input pixels.
- vsync_i, hsync_i, vde_i  in  1 each  input metadata.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i and ready_o are both high.
- pix_o  out  NumPix*3*PixW  processed pixels.
- vsync_o, hsync_o, vde_o  out  1 each  metadata, delayed identically to pix_o.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream ready.
- mode_o  out  3  currently active mode.
- frame_cnt_o  out  CntW  count of frames started.

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - all stage valid bits are 0; valid_o = 0; pix_o = 0; metadata outputs = 0.
  - mode_o = 0; active threshold = 0; frame_cnt_o = 0; previous-vsync flag = 0.
- Reset asserted mid-frame discards all in-flight beats. No partial beat emerges after release.
- Pipeline: Latency register stages, each holding a valid bit, data and metadata.
  - Stage k loads when it is empty or when stage k+1 (or the output, for the last stage) consumes its beat that cycle.
  - ready_o = stage 0 can load. This is combinational from ready_i through the stage valid bits only, never from valid_i.
  - Bubbles collapse.
  - Full throughput: with ready_i held high, one beat per cycle; a beat accepted at cycle t appears on the outputs at cycle t+Latency.
  - Output: valid_o = last stage valid. When valid_o = 1 and ready_i = 0, pix_o, metadata and valid_o stay stable until the handshake completes.
- Frame boundary:
  - Defined as an accepted beat with vsync_i = 1 while the previous-vsync flag is 0.
  - The previous-vsync flag updates only on accepted beats.
  - At a frame boundary, mode_i and thresh_i are latched into the active registers, and frame_cnt_o increments, wrapping from 2^CntW-1 to 0.
  - The boundary beat itself is already processed with the newly latched mode.
  - mode_i and thresh_i changes mid-frame have no effect.
- Colour function is per lane, computed from the active mode at the cycle the beat is accepted into stage 0. Each beat carries its own mode. Let M = 2^PixW-1.
  - 0 passthrough.
  - 1 invert: each channel c becomes M-c.
  - 2 grayscale: y = (r + 2g + b) >> 2, computed at PixW+2 bits, never overflowing; r = g = b = y.
  - 3 threshold: compute y as in mode 2; all channels = M if y >= thresh, else 0.
  - 4 R/B swap.
  - 5-7: passthrough.
- Blanking: a beat with vde = 0 outputs all-zero colour regardless of mode, with metadata unchanged.
- Metadata is never modified, only delayed.
- Simultaneous accept and emit in the same cycle is legal. A full pipeline with ready_i = 1 sustains 100% throughput.
- A frame boundary accepted while the pipeline holds old-mode beats does not retroactively alter those beats.

Test Plan (PixW=8, NumPix=1, Latency=2, CntW=8 unless stated):
- Reset, then valid_i=1, vde=1, mode 0, pix=0x123456, ready_i=1 -> valid_o rises 2 cycles after accept; pix_o=0x123456; metadata matches input.
- Frame boundary with mode_i=1, then pix 0x00FF80 -> pix_o=0xFF007F; mode_o=1; frame_cnt_o=1. Changing mode_i to 2 mid-frame -> no effect until the next boundary.
- Mode 2, pix r=0x10 g=0x20 b=0x30 -> y=0x20, pix_o=0x202020. Mode 3, thresh=0x20 -> 0xFFFFFF; thresh=0x21 -> 0x000000. Input 0xFFFFFF in mode 2 -> 0xFFFFFF (no overflow).
- Backpressure: stream 8 counting beats, toggle ready_i pseudo-randomly -> all 8 emerge in order, none lost or duplicated, outputs stable while stalled. With ready_i=0, ready_o falls after 2 beats are accepted.
- vde=0 beat with pix=0xABCDEF in mode 1 -> pix_o=0x000000, vde_o=0, hsync/vsync passed through. 256 frame boundaries -> frame_cnt_o wraps to 0.
- Reset asserted with 2 beats in flight -> valid_o=0 immediately (asynchronous); after release, mode_o=0, frame_cnt_o=0, no stale beat. Repeat the first scenario with NumPix=2, each lane processed independently.
